mac_tx_sched: RTL and testbench

Transmit scheduler in front of `mac_send`. It arbitrates round-robin between two frame requesters: requester 0 is the UDP path and requester 1 is the ARP/control path. It latches the winner's header fields and payload length, issues the single-cycle `tx_go` pulse, and selects which payload FIFO feeds `mac_send`. It then holds off the next frame for the frame duration plus a configurable inter-frame gap. It sits in the `gmii_clk` domain between the protocol builders and `mac_send`.

---
 rtl/mac_tx_sched.sv | 177 +++++++++++++++++
 tb/tb_mac_tx_sched.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : mac_tx_sched
// Purpose  : Round-robin transmit scheduler between UDP and ARP builders and mac_send.
// Revision : 1.0 - initial release
// ============================================================================
module mac_tx_sched #(
    parameter int FRAME_FIXED = 28,
    parameter int IFG_CYCLES  = 12,
    parameter int MAX_LEN     = 1500
) (
    input  logic        gmii_clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [10:0] len0,
    input  logic [10:0] len1,
    input  logic [15:0] type0,
    input  logic [15:0] type1,
    input  logic [47:0] dmac0,
    input  logic [47:0] dmac1,
    input  logic [47:0] cfg_src_mac,
    output logic        gnt0,
    output logic        gnt1,
    output logic        drop,
    output logic        tx_go,
    output logic [10:0] pyd_length,
    output logic [47:0] des_mac,
    output logic [47:0] src_mac,
    output logic [15:0] type_length,
    output logic        fifo_sel,
    output logic        busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_DROP   = 3'd2;
    localparam logic [2:0] S_SEND   = 3'd3;
    localparam logic [2:0] S_GAP    = 3'd4;

    localparam logic [11:0] c_FRAME_FIXED = 12'(FRAME_FIXED);
    localparam logic [11:0] c_IFG_LOAD    = 12'(IFG_CYCLES) - 12'd1;
    localparam logic [10:0] c_MAX_LEN     = 11'(MAX_LEN);

    logic [2:0]  state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic        last_q, last_d;
    logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic        drop_q, drop_d, tx_go_q, tx_go_d, busy_q, busy_d;
    logic        fifo_sel_q, fifo_sel_d;
    logic [10:0] pyd_length_q, pyd_length_d;
    logic [47:0] des_mac_q, des_mac_d, src_mac_q, src_mac_d;
    logic [15:0] type_length_q, type_length_d;

    logic        w_any;
    logic        w_pick;
    logic [10:0] w_len;
    logic        w_len_ok;

    // Under contention the requester that was not granted last time wins.
    assign w_any    = req0 | req1;
    assign w_pick   = (req0 & req1) ? ~last_q : req1;
    assign w_len    = w_pick ? len1 : len0;
    assign w_len_ok = (w_len != 11'd0) && (w_len <= c_MAX_LEN);

    always_ff @(posedge gmii_clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= 12'd0;
            last_q        <= 1'b1;
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            drop_q        <= 1'b0;
            tx_go_q       <= 1'b0;
            busy_q        <= 1'b0;
            fifo_sel_q    <= 1'b0;
            pyd_length_q  <= 11'd0;
            des_mac_q     <= 48'd0;
            src_mac_q     <= 48'd0;
            type_length_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_q        <= last_d;
            gnt0_q        <= gnt0_d;
            gnt1_q        <= gnt1_d;
            drop_q        <= drop_d;
            tx_go_q       <= tx_go_d;
            busy_q        <= busy_d;
            fifo_sel_q    <= fifo_sel_d;
            pyd_length_q  <= pyd_length_d;
            des_mac_q     <= des_mac_d;
            src_mac_q     <= src_mac_d;
            type_length_q <= type_length_d;
        end
    end

    always_comb begin : p_next
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (w_any) begin
                    state_d = w_len_ok ? S_LAUNCH : S_DROP;
                end
            end
            S_LAUNCH: begin
                cnt_d   = c_FRAME_FIXED + {1'b0, pyd_length_q} - 12'd1;
                state_d = S_SEND;
            end
            S_DROP: begin
                state_d = S_IDLE;
            end
            S_SEND: begin
                if (cnt_q == 12'd0) begin
                    cnt_d   = c_IFG_LOAD;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q - 12'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == 12'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 12'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 12'd0;
            end
        endcase
    end

    // Outputs are computed one cycle ahead so every port comes straight off a flop.
    always_comb begin : p_out
        gnt0_d        = 1'b0;
        gnt1_d        = 1'b0;
        tx_go_d       = 1'b0;
        drop_d        = 1'b0;
        last_d        = last_q;
        fifo_sel_d    = fifo_sel_q;
        pyd_length_d  = pyd_length_q;
        des_mac_d     = des_mac_q;
        src_mac_d     = src_mac_q;
        type_length_d = type_length_q;
        busy_d        = (state_d != S_IDLE);
        if ((state_q == S_IDLE) && w_any) begin
            last_d  = w_pick;
            gnt0_d  = ~w_pick;
            gnt1_d  = w_pick;
            tx_go_d = w_len_ok;
            drop_d  = ~w_len_ok;
            if (w_len_ok) begin
                fifo_sel_d    = w_pick;
                pyd_length_d  = w_len;
                des_mac_d     = w_pick ? dmac1 : dmac0;
                type_length_d = w_pick ? type1 : type0;
                src_mac_d     = cfg_src_mac;
            end
        end
    end

    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign drop        = drop_q;
    assign tx_go       = tx_go_q;
    assign busy        = busy_q;
    assign fifo_sel    = fifo_sel_q;
    assign pyd_length  = pyd_length_q;
    assign des_mac     = des_mac_q;
    assign src_mac     = src_mac_q;
    assign type_length = type_length_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_tx_sched
// Purpose  : Scoreboard bench for mac_tx_sched with directed request scenarios.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mac_tx_sched;

    logic        gmii_clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [10:0] len0 = '0, len1 = '0;
    logic [15:0] type0 = '0, type1 = '0;
    logic [47:0] dmac0 = '0, dmac1 = '0, cfg_src_mac = '0;
    logic        gnt0, gnt1, drop, tx_go, fifo_sel, busy;
    logic [10:0] pyd_length;
    logic [47:0] des_mac, src_mac;
    logic [15:0] type_length;

    mac_tx_sched #(.FRAME_FIXED(28), .IFG_CYCLES(12), .MAX_LEN(1500)) dut (
        .gmii_clk(gmii_clk), .rst(rst),
        .req0(req0), .req1(req1), .len0(len0), .len1(len1),
        .type0(type0), .type1(type1), .dmac0(dmac0), .dmac1(dmac1),
        .cfg_src_mac(cfg_src_mac),
        .gnt0(gnt0), .gnt1(gnt1), .drop(drop), .tx_go(tx_go),
        .pyd_length(pyd_length), .des_mac(des_mac), .src_mac(src_mac),
        .type_length(type_length), .fifo_sel(fifo_sel), .busy(busy)
    );

    always #4 gmii_clk = ~gmii_clk;

    int cyc = 0;
    always @(posedge gmii_clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          c;
        logic        id;
        logic        drp;
        logic [10:0] len;
        logic [15:0] typ;
        logic [47:0] dmac;
        logic [47:0] smac;
        logic        fsel;
    } exp_t;
    exp_t sb[$];

    task automatic push(input int c, input logic id, input logic drp, input logic [10:0] len,
                        input logic [15:0] typ, input logic [47:0] dm, input logic [47:0] sm,
                        input logic fs);
        exp_t e;
        e.c = c; e.id = id; e.drp = drp; e.len = len; e.typ = typ;
        e.dmac = dm; e.smac = sm; e.fsel = fs;
        sb.push_back(e);
    endtask

    // Monitor: every grant pulse is matched against the next scoreboard entry.
    always @(negedge gmii_clk) begin
        if (!rst) begin
            if (gnt0 || gnt1) begin
                chk("gnt_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("gnt_cycle",   64'(cyc),         64'(e.c));
                    chk("gnt0",        64'(gnt0),        64'(!e.id));
                    chk("gnt1",        64'(gnt1),        64'(e.id));
                    chk("drop",        64'(drop),        64'(e.drp));
                    chk("tx_go",       64'(tx_go),       64'(!e.drp));
                    chk("pyd_length",  64'(pyd_length),  64'(e.len));
                    chk("type_length", 64'(type_length), 64'(e.typ));
                    chk("des_mac",     64'(des_mac),     64'(e.dmac));
                    chk("src_mac",     64'(src_mac),     64'(e.smac));
                    chk("fifo_sel",    64'(fifo_sel),    64'(e.fsel));
                end
            end else if (tx_go || drop) begin
                chk("stray_pulse", {62'd0, tx_go, drop}, 64'd0);
            end
        end
    end

    int busy_run = 0;
    int last_run = 0;
    always @(negedge gmii_clk) begin
        if (rst) busy_run = 0;
        else if (busy) busy_run++;
        else if (busy_run != 0) begin
            last_run = busy_run;
            busy_run = 0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge gmii_clk);
        #1;
    endtask

    task automatic wait_gnt(input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge gmii_clk);
            if (gnt0 || gnt1) seen = 1'b1;
        end
        chk("gnt_seen", 64'(seen), 64'd1);
        step(1);
    endtask

    task automatic wait_idle(input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge gmii_clk);
            if (!busy) seen = 1'b1;
        end
        chk("idle_seen", 64'(seen), 64'd1);
        step(1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt0"},        64'(gnt0),        64'd0);
        chk({tag, "_gnt1"},        64'(gnt1),        64'd0);
        chk({tag, "_drop"},        64'(drop),        64'd0);
        chk({tag, "_tx_go"},       64'(tx_go),       64'd0);
        chk({tag, "_busy"},        64'(busy),        64'd0);
        chk({tag, "_fifo_sel"},    64'(fifo_sel),    64'd0);
        chk({tag, "_pyd_length"},  64'(pyd_length),  64'd0);
        chk({tag, "_des_mac"},     64'(des_mac),     64'd0);
        chk({tag, "_src_mac"},     64'(src_mac),     64'd0);
        chk({tag, "_type_length"}, 64'(type_length), 64'd0);
    endtask

    localparam logic [47:0] SRC_A = 48'h0200_0000_0001;
    localparam logic [47:0] SRC_B = 48'h0200_0000_0002;
    localparam logic [47:0] DM_0  = 48'h0000_5E00_0001;
    localparam logic [47:0] DM_1  = 48'h1122_3344_5566;
    localparam logic [47:0] DM_BC = 48'hFFFF_FFFF_FFFF;

    initial begin
        int k;
        cfg_src_mac = SRC_A;
        step(3);
        chk_all_zero("reset");
        rst = 1'b0;
        step(2);

        // Contention right after reset: requester 0 first, then alternate, 88 cycles apart.
        len0 = 11'd46; type0 = 16'h0800; dmac0 = DM_0;
        len1 = 11'd46; type1 = 16'h0806; dmac1 = DM_1;
        k = cyc;
        req0 = 1'b1; req1 = 1'b1;
        push(k + 1,   1'b0, 1'b0, 11'd46, 16'h0800, DM_0, SRC_A, 1'b0);
        push(k + 89,  1'b1, 1'b0, 11'd46, 16'h0806, DM_1, SRC_A, 1'b1);
        push(k + 177, 1'b0, 1'b0, 11'd46, 16'h0800, DM_0, SRC_A, 1'b0);
        push(k + 265, 1'b1, 1'b0, 11'd46, 16'h0806, DM_1, SRC_A, 1'b1);
        step(266);
        req0 = 1'b0; req1 = 1'b0;
        wait_idle(200);

        // Single UDP broadcast frame: busy spans 1 + 74 + 12 cycles.
        type0 = 16'h0800; dmac0 = DM_BC; len0 = 11'd46;
        k = cyc;
        req0 = 1'b1;
        push(k + 1, 1'b0, 1'b0, 11'd46, 16'h0800, DM_BC, SRC_A, 1'b0);
        wait_gnt(10);
        req0 = 1'b0;
        wait_idle(200);
        chk("busy_cycles", 64'(last_run), 64'd87);

        // Length rejection: zero and over-max on requester 1 leave headers untouched.
        cfg_src_mac = SRC_B;
        len1 = 11'd0; type1 = 16'h0806; dmac1 = DM_1;
        k = cyc;
        req1 = 1'b1;
        push(k + 1, 1'b1, 1'b1, 11'd46, 16'h0800, DM_BC, SRC_A, 1'b0);
        step(2);
        len1 = 11'd1501;
        push(k + 3, 1'b1, 1'b1, 11'd46, 16'h0800, DM_BC, SRC_A, 1'b0);
        step(2);
        req1 = 1'b0;
        chk("drop_busy_idle", 64'(busy), 64'd0);

        // Maximum frame, re-requested immediately: 1542 cycles between launches.
        len0 = 11'd1500; type0 = 16'h0800; dmac0 = DM_0;
        req0 = 1'b1;
        push(k + 5,    1'b0, 1'b0, 11'd1500, 16'h0800, DM_0, SRC_B, 1'b0);
        push(k + 1547, 1'b0, 1'b0, 11'd1500, 16'h0800, DM_0, SRC_B, 1'b0);
        step(1544);
        req0 = 1'b0;
        wait_idle(1700);
        chk("busy_cycles_max", 64'(last_run), 64'd1541);

        // Late request: req1 raised in GAP waits for IDLE.
        len0 = 11'd46; dmac0 = DM_BC;
        k = cyc;
        req0 = 1'b1;
        push(k + 1, 1'b0, 1'b0, 11'd46, 16'h0800, DM_BC, SRC_B, 1'b0);
        wait_gnt(10);
        req0 = 1'b0;
        step(78);
        len1 = 11'd64; type1 = 16'h0806; dmac1 = DM_1;
        req1 = 1'b1;
        push(k + 89, 1'b1, 1'b0, 11'd64, 16'h0806, DM_1, SRC_B, 1'b1);
        wait_gnt(20);
        req1 = 1'b0;

        // Reset ten cycles into SEND of the requester-1 frame.
        step(10);
        chk("pre_reset_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        len0 = 11'd46; type0 = 16'h0800; dmac0 = DM_0;
        req0 = 1'b1;
        #1;
        chk_all_zero("midreset");
        step(3);
        rst = 1'b0;
        k = cyc;
        push(k + 1, 1'b0, 1'b0, 11'd46, 16'h0800, DM_0, SRC_B, 1'b0);
        wait_gnt(10);
        req0 = 1'b0;
        wait_idle(200);

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
